// File: rtl/luhn_modn_engine_if.sv
// Handshake bundle between the message framer and the Luhn mod-N engine.
// Latency: n/a (wires only).
// Backpressure: size, data and result channels each use valid/ready.
// Ports: master = framer/consumer side, slave = engine side.
interface luhn_modn_engine_if #(
  parameter int DATA_W = 4,
  parameter int SIZE_W = 8
);
  logic [SIZE_W-1:0] size;
  logic              mode;
  logic              size_valid;
  logic              size_ready;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic              check;
  logic [DATA_W-1:0] check_char;
  logic              check_valid;
  logic              check_ready;

  modport master (
    output size, mode, size_valid, data, data_valid, check_ready,
    input  size_ready, data_ready, check, check_char, check_valid
  );

  modport slave (
    input  size, mode, size_valid, data, data_valid, check_ready,
    output size_ready, data_ready, check, check_char, check_valid
  );
endinterface

// File: rtl/luhn_modn_engine.sv
// Luhn mod-2**DATA_W engine: CHECK verifies a message, GEN produces its check character.
// Latency: result valid the cycle after the last data handshake (or after size handshake when size==0).
// Backpressure: data stalls on data_valid low; result held stable until check_ready.
// Ports: clock, rst_n (synchronous, active-low), bus (slave side of luhn_modn_engine_if).
module luhn_modn_engine #(
  parameter int DATA_W = 4,
  parameter int SIZE_W = 8
) (
  input logic               clock,
  input logic               rst_n,
  luhn_modn_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [SIZE_W-1:0] remaining, remaining_nxt;
  logic              mode_q, mode_nxt;
  logic              dbl;
  logic [DATA_W-1:0] term;
  logic              in_done;

  // remaining = characters still to come, including the current one.
  // In CHECK the current right-index is remaining-1, in GEN it is remaining,
  // so the doubling decision is just the LSB of remaining, flipped for CHECK.
  always_comb begin
    dbl = mode_q ? remaining[0] : ~remaining[0];
    if (dbl) begin
      // 2d = {carry, low}; folding the carry back in is the base-N digit sum.
      term = {bus.data[DATA_W-2:0], 1'b0}
           + {{(DATA_W-1){1'b0}}, bus.data[DATA_W-1]};
    end else begin
      term = bus.data;
    end
  end

  // Readies/valid are gated by rst_n so nothing handshakes while reset is held.
  assign in_done         = rst_n && (state == DONE);
  assign bus.size_ready  = rst_n && (state == IDLE);
  assign bus.data_ready  = rst_n && (state == DATA);
  assign bus.check_valid = in_done;
  assign bus.check       = in_done && (mode_q || (acc == '0));
  assign bus.check_char  = !in_done ? '0
                         : (mode_q ? ({DATA_W{1'b0}} - acc) : acc);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    mode_nxt      = mode_q;
    case (state)
      IDLE: begin
        if (bus.size_valid) begin
          mode_nxt      = bus.mode;
          remaining_nxt = bus.size;
          acc_nxt       = '0;
          state_nxt     = (bus.size == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (bus.data_valid) begin
          acc_nxt       = acc + term;
          remaining_nxt = remaining - SIZE_W'(1);
          if (remaining == SIZE_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.check_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      mode_q    <= mode_nxt;
    end
  end

endmodule
